micro_sequencer: RTL and testbench

- Microprogram sequencer for the microcoded CISC datapath.
- Drives the control-store address (upc) and the instruction-register load strobe.
- Takes dispatch addresses ib (addressing-mode entry) and sb (operation entry) from the instruction decoder, plus a next-address op from the current control word.
- Provides increment, jump, conditional branch on the zero flag, one-level-deep-or-more microsubroutine call/return, and return to instruction fetch.

---
 rtl/micro_sequencer.sv | 138 +++++++++++++
 tb/tb_micro_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: fetch/decode/exec control, next-address selection
// and a small return stack for microsubroutine call/return.
module micro_sequencer #(
  parameter int AW          = 5,
  parameter int STACK_DEPTH = 2,
  parameter int FETCH_ADDR  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ins_valid,
  output logic          ir_load,
  input  logic [AW-1:0] ib,
  input  logic [AW-1:0] sb,
  input  logic [2:0]    seq_op,
  input  logic [AW-1:0] br_addr,
  input  logic          zero_flag,
  input  logic          mem_wait,
  output logic [AW-1:0] upc,
  output logic          upc_valid,
  output logic          busy,
  output logic          stk_ovf,
  output logic          stk_unf
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [AW-1:0]  FA   = AW'(FETCH_ADDR);
  localparam logic [SPW-1:0] FULL = SPW'(STACK_DEPTH);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC} state_t;

  localparam logic [2:0] OP_INC = 3'b000, OP_JMP = 3'b001, OP_DIB = 3'b010,
                         OP_DSB = 3'b011, OP_BZ  = 3'b100, OP_CALL = 3'b101,
                         OP_RET = 3'b110, OP_END = 3'b111;

  state_t         state, state_n;
  logic [AW-1:0]  upc_n, upc_inc, pop_data;
  logic [SPW-1:0] sp, sp_n;
  logic           ovf_n, unf_n, push;
  logic           fetch_q;
  logic [AW-1:0]  stack [STACK_DEPTH];

  assign upc_inc = upc + 1'b1;

  // fetch_q is a dedicated flop so ir_load never sees a state-decode glitch
  assign ir_load = rst & fetch_q & ins_valid;

  always_comb begin
    pop_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (sp == SPW'(i + 1)) pop_data = stack[i];
  end

  always_comb begin
    state_n = state;
    upc_n   = upc;
    sp_n    = sp;
    ovf_n   = stk_ovf;
    unf_n   = stk_unf;
    push    = 1'b0;
    case (state)
      FETCH: begin
        upc_n = FA;
        if (ins_valid) state_n = DECODE;
      end
      DECODE: begin
        upc_n   = ib;
        state_n = EXEC;
      end
      EXEC: begin
        if (!mem_wait) begin
          case (seq_op)
            OP_INC: upc_n = upc_inc;
            OP_JMP: upc_n = br_addr;
            OP_DIB: upc_n = ib;
            OP_DSB: upc_n = sb;
            OP_BZ:  upc_n = zero_flag ? br_addr : upc_inc;
            OP_CALL: begin
              upc_n = br_addr;
              if (sp == FULL) ovf_n = 1'b1;
              else begin
                push = 1'b1;
                sp_n = sp + 1'b1;
              end
            end
            OP_RET: begin
              if (sp == '0) begin
                upc_n   = FA;
                state_n = FETCH;
                unf_n   = 1'b1;
              end else begin
                upc_n = pop_data;
                sp_n  = sp - 1'b1;
              end
            end
            default: begin
              upc_n   = FA;
              sp_n    = '0;
              state_n = FETCH;
            end
          endcase
        end
      end
      default: begin
        upc_n   = FA;
        state_n = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FETCH;
      upc       <= FA;
      sp        <= '0;
      stk_ovf   <= 1'b0;
      stk_unf   <= 1'b0;
      upc_valid <= 1'b0;
      busy      <= 1'b0;
      fetch_q   <= 1'b1;
    end else begin
      state     <= state_n;
      upc       <= upc_n;
      sp        <= sp_n;
      stk_ovf   <= ovf_n;
      stk_unf   <= unf_n;
      upc_valid <= (state_n == EXEC);
      busy      <= (state_n != FETCH);
      fetch_q   <= (state_n == FETCH);
    end
  end

  // Contents need no reset: sp alone defines which entries are live
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++)
      if (push && sp == SPW'(i)) stack[i] <= upc_inc;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed table-driven bench for micro_sequencer with hand-computed expectations.
module tb_micro_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       ins_valid, ir_load;
  logic [4:0] ib, sb, br_addr, upc;
  logic [2:0] seq_op;
  logic       zero_flag, mem_wait, upc_valid, busy, stk_ovf, stk_unf;

  int n_total = 0;
  int n_pass  = 0;

  micro_sequencer #(.AW(5), .STACK_DEPTH(2), .FETCH_ADDR(0)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ir_load(ir_load),
    .ib(ib), .sb(sb), .seq_op(seq_op), .br_addr(br_addr),
    .zero_flag(zero_flag), .mem_wait(mem_wait), .upc(upc),
    .upc_valid(upc_valid), .busy(busy), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [4:0] ib, sb;
    logic [2:0] op;
    logic [4:0] br;
    logic       z, mw;
    logic       irl;
    logic [4:0] upc;
    logic       vld, bsy, ovf, unf;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic iv, logic [4:0] ib_v, logic [4:0] sb_v, logic [2:0] op,
                              logic [4:0] br, logic z, logic mw, logic irl, logic [4:0] u,
                              logic vld, logic bsy, logic ovf, logic unf);
    vec_t v;
    v.iv = iv; v.ib = ib_v; v.sb = sb_v; v.op = op; v.br = br; v.z = z; v.mw = mw;
    v.irl = irl; v.upc = u; v.vld = vld; v.bsy = bsy; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one vector, check ir_load before the edge and registered outputs after it.
  task automatic run(string tag, vec_t v);
    ins_valid = v.iv; ib = v.ib; sb = v.sb; seq_op = v.op;
    br_addr = v.br; zero_flag = v.z; mem_wait = v.mw;
    #1;
    chk({tag, " ir_load"}, 32'(ir_load), 32'(v.irl));
    @(posedge clk); #1;
    chk({tag, " upc"},       32'(upc),       32'(v.upc));
    chk({tag, " upc_valid"}, 32'(upc_valid), 32'(v.vld));
    chk({tag, " busy"},      32'(busy),      32'(v.bsy));
    chk({tag, " stk_ovf"},   32'(stk_ovf),   32'(v.ovf));
    chk({tag, " stk_unf"},   32'(stk_unf),   32'(v.unf));
  endtask

  localparam logic [2:0] INC = 0, JMP = 1, DIB = 2, DSB = 3, BZ = 4, CALL = 5, RET = 6, ENDOP = 7;

  initial begin
    rst = 1'b0; ins_valid = 0; ib = 0; sb = 0; seq_op = 0; br_addr = 0; zero_flag = 0; mem_wait = 0;

    //         iv ib  sb  op    br  z  mw irl upc v  b  ovf unf
    tv.push_back(mk(1, 5,  0, INC,  0, 0, 0, 1,  0, 0, 1, 0, 0));
    tv.push_back(mk(1, 5,  0, INC,  0, 0, 0, 0,  5, 1, 1, 0, 0));
    tv.push_back(mk(0, 5,  0, JMP,  3, 0, 0, 0,  3, 1, 1, 0, 0));
    tv.push_back(mk(1, 5,  0, INC,  0, 0, 0, 0,  4, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, JMP, 20, 0, 0, 0, 20, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 13, DSB,  0, 0, 0, 0, 13, 1, 1, 0, 0));
    tv.push_back(mk(0, 7,  0, DIB,  0, 0, 0, 0,  7, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, ENDOP,0, 0, 0, 0,  0, 0, 0, 0, 0));
    tv.push_back(mk(1, 6,  0, INC,  0, 0, 0, 1,  0, 0, 1, 0, 0));
    tv.push_back(mk(0, 6,  0, INC,  0, 0, 0, 0,  6, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, BZ,   9, 1, 0, 0,  9, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, JMP,  6, 0, 0, 0,  6, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, BZ,   9, 0, 0, 0,  7, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, JMP, 31, 0, 0, 0, 31, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, INC,  0, 0, 0, 0,  0, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, JMP,  4, 0, 0, 0,  4, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, CALL,10, 0, 0, 0, 10, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, CALL,20, 0, 0, 0, 20, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, RET,  0, 0, 0, 0, 11, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, RET,  0, 0, 0, 0,  5, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, CALL,10, 0, 0, 0, 10, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, CALL,20, 0, 0, 0, 20, 1, 1, 0, 0));
    tv.push_back(mk(0, 0,  0, CALL,25, 0, 0, 0, 25, 1, 1, 1, 0));
    tv.push_back(mk(0, 0,  0, RET,  0, 0, 0, 0, 11, 1, 1, 1, 0));
    tv.push_back(mk(0, 0,  0, RET,  0, 0, 0, 0,  6, 1, 1, 1, 0));
    tv.push_back(mk(0, 0,  0, RET,  0, 0, 0, 0,  0, 0, 0, 1, 1));
    tv.push_back(mk(0, 0,  0, INC,  0, 0, 0, 0,  0, 0, 0, 1, 1));
    tv.push_back(mk(1, 2,  0, INC,  0, 0, 1, 1,  0, 0, 1, 1, 1));
    tv.push_back(mk(0, 2,  0, INC,  0, 0, 1, 0,  2, 1, 1, 1, 1));
    tv.push_back(mk(0, 0,  0, CALL,17, 0, 1, 0,  2, 1, 1, 1, 1));
    tv.push_back(mk(0, 0,  0, CALL,17, 0, 1, 0,  2, 1, 1, 1, 1));
    tv.push_back(mk(0, 0,  0, CALL,17, 0, 1, 0,  2, 1, 1, 1, 1));
    tv.push_back(mk(0, 0,  0, CALL,17, 0, 0, 0, 17, 1, 1, 1, 1));
    tv.push_back(mk(0, 0,  0, RET,  0, 0, 0, 0,  3, 1, 1, 1, 1));
    tv.push_back(mk(0, 0,  0, ENDOP,0, 0, 0, 0,  0, 0, 0, 1, 1));

    #12 rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d upc", c),       32'(upc),       0);
      chk($sformatf("idle%0d upc_valid", c), 32'(upc_valid), 0);
      chk($sformatf("idle%0d busy", c),      32'(busy),      0);
      chk($sformatf("idle%0d ir_load", c),   32'(ir_load),   0);
    end

    for (int i = 0; i < tv.size(); i++) run($sformatf("v%0d", i), tv[i]);

    // Asynchronous reset mid-routine with a live stack entry
    run("ar0", mk(1, 8, 0, INC,  0, 0, 0, 1,  0, 0, 1, 1, 1));
    run("ar1", mk(0, 8, 0, INC,  0, 0, 0, 0,  8, 1, 1, 1, 1));
    run("ar2", mk(0, 0, 0, CALL,12, 0, 0, 0, 12, 1, 1, 1, 1));
    #2;
    ins_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk("areset upc",       32'(upc),       0);
    chk("areset upc_valid", 32'(upc_valid), 0);
    chk("areset busy",      32'(busy),      0);
    chk("areset stk_ovf",   32'(stk_ovf),   0);
    chk("areset stk_unf",   32'(stk_unf),   0);
    chk("areset ir_load",   32'(ir_load),   0);
    ins_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("held upc", 32'(upc), 0);
    // Stack was discarded: the first RET of the next routine underflows
    run("pr0", mk(1, 8, 0, INC, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    run("pr1", mk(0, 8, 0, INC, 0, 0, 0, 0, 8, 1, 1, 0, 0));
    run("pr2", mk(0, 0, 0, RET, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
